multicycle_control: RTL and testbench

- Multicycle control FSM for the 32-bit MIPS-subset datapath.
- Sits directly upstream of the ALU and drives its 3-bit ALUControl plus all datapath mux selects and write enables.
- Consumes the opcode and funct fields from the instruction register and the ALU zero flag.
- Sequences each instruction over 3–5 cycles and counts retired instructions.

---
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: drives ALU op, datapath selects,
// write enables, and counts retired legal instructions.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   op, funct, zero     instruction fields and ALU zero flag
//   ALUControl..PCEn    datapath controls decoded from state
//   illegalOp           one-cycle pulse on bad op or funct
//   retired             retired-instruction counter (wraps)
module multicycle_control #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic [2:0]           ALUControl,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 illegalOp,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic mem_write_d;
  logic ir_write_d;
  logic reg_write_d;
  logic pc_en_d;
  logic illegal_d;
  logic retire_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    ALUControl  = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    pc_en_d     = 1'b0;
    illegal_d   = 1'b0;
    retire_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ir_write_d = 1'b1;
        pc_en_d    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      S_MEMWRITE: begin
        IorD        = 1'b1;
        mem_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          6'b100000: ALUControl = 3'b000;
          6'b100010: ALUControl = 3'b001;
          6'b100100: ALUControl = 3'b010;
          6'b100101: ALUControl = 3'b011;
          6'b101010: ALUControl = 3'b101;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b100;
        PCSrc      = 2'b01;
        pc_en_d    = zero;
        retire_d   = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_en_d  = 1'b1;
        retire_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + CNT_WIDTH'(retire_d);

  // Enables are gated by reset so nothing fires while rst_n is low.
  assign MemWrite  = mem_write_d & rst_n;
  assign IRWrite   = ir_write_d  & rst_n;
  assign RegWrite  = reg_write_d & rst_n;
  assign PCEn      = pc_en_d     & rst_n;
  assign illegalOp = illegal_d   & rst_n;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an
// instruction-level model; runs a 32-bit and a 4-bit counter DUT.
module tb_multicycle_control;

  localparam int K_LW    = 0;
  localparam int K_SW    = 1;
  localparam int K_R     = 2;
  localparam int K_RBAD  = 3;
  localparam int K_BEQ   = 4;
  localparam int K_ADDI  = 5;
  localparam int K_J     = 6;
  localparam int K_BADOP = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic [2:0]  a_alu, b_alu;
  logic        a_sa, b_sa;
  logic [1:0]  a_sb, b_sb;
  logic        a_iord, b_iord;
  logic        a_mw, b_mw;
  logic        a_irw, b_irw;
  logic        a_rd, b_rd;
  logic        a_m2r, b_m2r;
  logic        a_rw, b_rw;
  logic [1:0]  a_pcs, b_pcs;
  logic        a_pce, b_pce;
  logic        a_ill, b_ill;
  logic [31:0] a_ret;
  logic [3:0]  b_ret;

  logic [31:0] model_ret;
  int          n_tests = 0;
  int          n_fail  = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .ALUControl(a_alu), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
    .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw),
    .RegDst(a_rd), .MemtoReg(a_m2r), .RegWrite(a_rw),
    .PCSrc(a_pcs), .PCEn(a_pce), .illegalOp(a_ill),
    .retired(a_ret)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .ALUControl(b_alu), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
    .IorD(b_iord), .MemWrite(b_mw), .IRWrite(b_irw),
    .RegDst(b_rd), .MemtoReg(b_m2r), .RegWrite(b_rw),
    .PCSrc(b_pcs), .PCEn(b_pce), .illegalOp(b_ill),
    .retired(b_ret)
  );

  always #5 clk = ~clk;

  wire [15:0] vec_a = {a_alu, a_sa, a_sb, a_iord, a_mw, a_irw,
                       a_rd, a_m2r, a_rw, a_pcs, a_pce, a_ill};
  wire [15:0] vec_b = {b_alu, b_sa, b_sb, b_iord, b_mw, b_irw,
                       b_rd, b_m2r, b_rw, b_pcs, b_pce, b_ill};
  wire [9:0]  ens   = {a_mw, a_irw, a_rw, a_pce, a_ill,
                       b_mw, b_irw, b_rw, b_pce, b_ill};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(
    logic [2:0] alu, logic sa, logic [1:0] sb, logic iord,
    logic mw, logic irw, logic rd, logic m2r, logic rw,
    logic [1:0] pcs, logic pce, logic ill);
    return {alu, sa, sb, iord, mw, irw, rd, m2r, rw, pcs, pce, ill};
  endfunction

  function automatic bit legal_f(logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100,
                     6'b100101, 6'b101010};
  endfunction

  function automatic bit legal_op(logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000,
                     6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic int lat(int k);
    case (k)
      K_LW:                    return 5;
      K_SW, K_R, K_ADDI:       return 4;
      K_BEQ, K_J, K_RBAD:      return 3;
      default:                 return 2;
    endcase
  endfunction

  // Expected controls for cycle cyc of an instruction of kind k.
  function automatic logic [15:0] exp_out(int k, int cyc,
                                          logic [5:0] f, logic z);
    if (cyc == 0) return pk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    if (cyc == 1) return pk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,
                            k == K_BADOP);
    case (k)
      K_LW, K_SW: begin
        if (cyc == 2) return pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (cyc == 3) return pk(0, 0, 0, 1, k == K_SW, 0, 0, 0, 0,
                                0, 0, 0);
        return pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      end
      K_R: begin
        if (cyc == 2) return pk(r_alu(f), 1, 0, 0, 0, 0, 0, 0, 0,
                                0, 0, 0);
        return pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      end
      K_RBAD: return pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      K_BEQ:  return pk(3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 1, z, 0);
      K_ADDI: begin
        if (cyc == 2) return pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      end
      K_J:    return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      default: return 16'h0;
    endcase
  endfunction

  task automatic run(input int k, input logic [5:0] o,
                     input logic [5:0] f, input logic z,
                     input int abort_at = -1);
    for (int cyc = 0; cyc < lat(k); cyc++) begin
      op    = (cyc == 1 || (cyc == 2 && (k == K_LW || k == K_SW)))
              ? o : 6'($urandom);
      funct = (cyc == 2) ? f : 6'($urandom);
      zero  = (cyc == 2) ? z : 1'($urandom);
      #1;
      chk("ctl32", {16'h0, vec_a}, {16'h0, exp_out(k, cyc, f, z)});
      chk("ctl4", {16'h0, vec_b}, {16'h0, exp_out(k, cyc, f, z)});
      chk("ret32", a_ret, model_ret);
      chk("ret4", {28'h0, b_ret}, {28'h0, model_ret[3:0]});
      if (cyc == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", {22'h0, ens}, 32'h0);
        chk("rst_ret32", a_ret, 32'h0);
        chk("rst_ret4", {28'h0, b_ret}, 32'h0);
        model_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (k != K_RBAD && k != K_BADOP) model_ret++;
  endtask

  task automatic run_rand();
    int k;
    logic [5:0] o, f;
    logic [5:0] good [5];
    good[0] = 6'b100000; good[1] = 6'b100010; good[2] = 6'b100100;
    good[3] = 6'b100101; good[4] = 6'b101010;
    k = $urandom_range(0, 7);
    f = 6'($urandom);
    case (k)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_BEQ:  o = 6'b000100;
      K_ADDI: o = 6'b001000;
      K_J:    o = 6'b000010;
      default: o = 6'b000000;
    endcase
    if (k == K_R) f = good[$urandom_range(0, 4)];
    if (k == K_RBAD) while (legal_f(f)) f = 6'($urandom);
    if (k == K_BADOP) begin
      o = 6'($urandom);
      while (legal_op(o)) o = 6'($urandom);
    end
    run(k, o, f, 1'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    op = '0;
    funct = '0;
    zero = 1'b0;
    model_ret = '0;
    #3;
    chk("rst_hold_en", {22'h0, ens}, 32'h0);
    chk("rst_hold_ret", a_ret, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(K_LW, 6'b100011, 6'h00, 1'b0);
    run(K_R, 6'b000000, 6'b101010, 1'b0);
    run(K_R, 6'b000000, 6'b100010, 1'b1);
    run(K_BEQ, 6'b000100, 6'h00, 1'b1);
    run(K_BEQ, 6'b000100, 6'h00, 1'b0);
    run(K_BADOP, 6'b111111, 6'h00, 1'b0);
    run(K_RBAD, 6'b000000, 6'b000111, 1'b0);
    run(K_SW, 6'b101011, 6'h00, 1'b0);
    run(K_ADDI, 6'b001000, 6'h00, 1'b0);
    run(K_LW, 6'b100011, 6'h00, 1'b0, 3);
    run(K_J, 6'b000010, 6'h00, 1'b0);

    for (int i = 0; i < 200; i++) run_rand();

    for (int i = 0; i < 16; i++) run(K_J, 6'b000010, 6'h00, 1'b0);
    #1;
    chk("final_ret32", a_ret, model_ret);
    chk("final_ret4", {28'h0, b_ret}, {28'h0, model_ret[3:0]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
